// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared constants and elaboration helpers for pipelined_add_sub
//
// Package addsub_pkg
//   OP_ADD / OP_SUB : encoding of the sub control input
//   calc_stages()   : pipeline depth derived from operand width and chunk width
//   chunk_ok()      : legality of an (N, CHUNK) pair, checked at elaboration by the top
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One ripple segment per pipeline stage, so depth is simply the chunk count.
  function automatic int calc_stages(input int n, input int chunk);
    if (chunk <= 0) begin
      return 1;
    end
    return n / chunk;
  endfunction

  // The carry chain has to split into whole segments; a partial top segment
  // would need its own stage shape and is not supported.
  function automatic bit chunk_ok(input int n, input int chunk);
    return (chunk > 0) && (n > 0) && (chunk <= n) && ((n % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result handshake bundle for pipelined_add_sub
//
// Interface pipelined_add_sub_if #(N)
//   Upstream side   : in_valid, in_ready, a[N], b[N], sub
//   Downstream side : out_valid, out_ready, s[N], c_out, ovf, zero
// Modports
//   master : the agent that supplies operands and consumes results
//   slave  : the adder/subtractor itself
interface pipelined_add_sub_if #(
  parameter int N = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero
  );

endinterface

// File: rtl/pipelined_add_sub_chunk.sv
// rtl/pipelined_add_sub_chunk.sv - one W-bit ripple segment of the pipelined carry chain
//
// Module addsub_chunk #(W)
//   a_i[W], b_i[W] : operand slice (b already conditioned for subtraction)
//   c_i            : carry into the segment LSB
//   sum_o[W]       : segment sum
//   c_o            : carry out of the segment MSB
//   c_msb_o        : carry into the segment MSB (used for signed overflow on the top segment)
module addsub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         c_o,
  output logic         c_msb_o
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = carry[W];
  assign c_msb_o = carry[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - carry-pipelined N-bit adder/subtractor with valid/ready handshake
//
// Module pipelined_add_sub #(N, CHUNK)
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every valid bit and the result registers
//   bus   : pipelined_add_sub_if.slave carrying operands (a, b, sub, in_valid/in_ready)
//           and results (s, c_out, ovf, zero, out_valid/out_ready)
//
// The N-bit carry chain is cut into N/CHUNK ripple segments, one per stage.
// Stage k resolves bits [k*CHUNK +: CHUNK]; the still-unprocessed upper operand
// bits ride along with it and the already-resolved lower sum bits accumulate,
// so every stage register is exactly as wide as what remains to be carried.
// Latency equals the stage count; one global advance enable stalls all stages.
//
// Build option: define ADDSUB_SAT_EN to clamp s to the signed limit on overflow.
// Without it s wraps modulo 2^N and no clamp logic exists.
module pipelined_add_sub
  import addsub_pkg::*;
#(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_add_sub_if.slave   bus
);

  localparam int STAGES = calc_stages(N, CHUNK);

  if (!chunk_ok(N, CHUNK)) begin : g_bad_chunk
    $error("pipelined_add_sub: N must be a positive multiple of CHUNK");
  end

  // Whole pipeline moves together: it may advance whenever the output slot is
  // empty or being drained this cycle. Bubbles therefore travel but never collapse.
  logic adv;

  logic         out_v_q;
  logic [N-1:0] s_q;
  logic [N-1:0] s_d;
  logic         c_out_q;
  logic         ovf_q;
  logic         ovf_d;
  logic         zero_q;
  logic         zero_d;

  // Combinational result of the last segment, before the output register.
  logic [N-1:0] fin_s;
  logic         fin_c;
  logic         fin_cm;
  logic         fin_v;

  logic         sub_op;

  assign adv          = !out_v_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign sub_op       = (bus.sub == OP_SUB);

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM_IN = N - k * CHUNK;     // operand bits not yet resolved
    localparam int DONE   = (k + 1) * CHUNK;   // sum bits resolved after this stage

    logic [REM_IN-1:0] a_in;
    logic [REM_IN-1:0] b_in;
    logic              c_in;
    logic              v_in;
    logic [DONE-1:0]   s_acc;
    logic [CHUNK-1:0]  sum;
    logic              cout;
    logic              cmsb;

    addsub_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .a_i     (a_in[CHUNK-1:0]),
      .b_i     (b_in[CHUNK-1:0]),
      .c_i     (c_in),
      .sum_o   (sum),
      .c_o     (cout),
      .c_msb_o (cmsb)
    );

    if (k == 0) begin : g_head
      // Subtraction as A + ~B + 1: invert B and inject the +1 as carry-in.
      assign a_in  = bus.a;
      assign b_in  = bus.b ^ {N{sub_op}};
      assign c_in  = sub_op;
      assign v_in  = bus.in_valid;
      assign s_acc = sum;
    end else begin : g_body
      assign a_in  = g_stg[k-1].g_reg.a_q;
      assign b_in  = g_stg[k-1].g_reg.b_q;
      assign c_in  = g_stg[k-1].g_reg.c_q;
      assign v_in  = g_stg[k-1].g_reg.v_q;
      assign s_acc = {sum, g_stg[k-1].g_reg.s_q};
    end

    if (k < STAGES - 1) begin : g_reg
      localparam int REM = N - DONE;

      logic            v_q;
      logic [REM-1:0]  a_q;
      logic [REM-1:0]  b_q;
      logic [DONE-1:0] s_q;
      logic            c_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          v_q <= v_in;
          a_q <= a_in[REM_IN-1:CHUNK];
          b_q <= b_in[REM_IN-1:CHUNK];
          s_q <= s_acc;
          c_q <= cout;
        end
      end
    end else begin : g_last
      assign fin_s  = s_acc;
      assign fin_c  = cout;
      assign fin_cm = cmsb;
      assign fin_v  = v_in;
    end
  end

  // Final stage: flags and optional clamp are folded in ahead of the output
  // register so they cost no extra cycle.
  always_comb begin
    ovf_d = fin_cm ^ fin_c;
    s_d   = fin_s;
`ifdef ADDSUB_SAT_EN
    // A wrapped result with MSB set can only come from two positive operands,
    // so it clamps high; a wrapped result with MSB clear clamps low.
    if (ovf_d) begin
      s_d = fin_s[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
    end
`endif
    zero_d = (s_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      out_v_q <= fin_v;
      s_q     <= s_d;
      c_out_q <= fin_c;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
